fir_tap_mac: RTL

Serial multiply-accumulate stage that sits directly downstream of the 64-entry sample delay line in each equalizer band filter. Each output sample takes 64 tap cycles. In each tap cycle it receives one delayed sample, `delay_filter_in`, and the matching coefficient. It multiplies them in a registered pipeline and accumulates the products. After the last tap it emits one rounded, saturated 16-bit filter output with a single-cycle valid pulse.

---
 rtl/eq_fir_defs_pkg.sv | 15 +
 rtl/fir_round_sat.sv | 34 +++
 rtl/fir_tap_mac.sv | 110 +++++++++++
 3 files changed

// File: rtl/eq_fir_defs_pkg.sv
// Shared definitions for the equalizer band filter blocks (delay line, counter,
// coefficient ROM, tap MAC and band summation).
package eq_fir_defs;

  localparam int NUM_TAPS  = 64;
  localparam int DATA_W    = 16;
  localparam int COEF_FRAC = 15;
  localparam int ACC_W     = 40;
  localparam int IDX_W     = 6;
  localparam int PROD_W    = 2 * DATA_W;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, drop the coefficient fraction and clamp an accumulator value
// to a 16-bit signed sample.
module fir_round_sat
  import eq_fir_defs::*;
#(
  parameter int ACC_W     = eq_fir_defs::ACC_W,
  parameter int COEF_FRAC = eq_fir_defs::COEF_FRAC
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [15:0]      sat_out
);

  localparam logic signed [ACC_W-1:0] HALF_LSB =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  // Headroom above the 38-bit worst-case sum keeps the rounding add from wrapping.
  always_comb begin
    rounded = acc_in + HALF_LSB;
    shifted = rounded >>> COEF_FRAC;
    if (shifted > SAT_HI) begin
      sat_out = 16'sd32767;
    end else if (shifted < SAT_LO) begin
      sat_out = -16'sd32768;
    end else begin
      sat_out = shifted[15:0];
    end
  end

endmodule

// File: rtl/fir_tap_mac.sv
// Serial multiply-accumulate for one band filter: one tap per cycle, one
// rounded/saturated output per complete 0..NUM_TAPS-1 tap sequence.
module fir_tap_mac
  import eq_fir_defs::*;
#(
  parameter int NUM_TAPS  = eq_fir_defs::NUM_TAPS,
  parameter int DATA_W    = eq_fir_defs::DATA_W,
  parameter int COEF_FRAC = eq_fir_defs::COEF_FRAC,
  parameter int ACC_W     = eq_fir_defs::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tap_valid,
  input  logic [IDX_W-1:0]         current_count,
  input  logic signed [DATA_W-1:0] delay_filter_in,
  input  logic signed [DATA_W-1:0] coeff_in,
  output logic signed [15:0]       filter_out,
  output logic                     out_valid,
  output logic                     seq_err
);

  localparam int MUL_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  logic signed [MUL_W-1:0] prod_q;
  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic                    frame_open;
  logic                    acc_done;

  logic signed [15:0]      sat_value;
  logic [IDX_W-1:0]        exp_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= tap_valid;
      if (tap_valid) begin
        prod_q   <= delay_filter_in * coeff_in;
        s1_first <= (current_count == '0);
        s1_last  <= (current_count == LAST_IDX);
      end
    end
  end

  assign prod_ext = ACC_W'(prod_q);

  // frame_open marks that tap 0 was absorbed, so a last tap only completes a
  // frame that really started at index 0 (e.g. not a tail seen after reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      frame_open <= 1'b0;
      acc_done   <= 1'b0;
    end else begin
      acc_done <= s1_valid && s1_last && (s1_first || frame_open);
      if (s1_valid) begin
        acc_q <= s1_first ? prod_ext : acc_q + prod_ext;
        if (s1_last) begin
          frame_open <= 1'b0;
        end else if (s1_first) begin
          frame_open <= 1'b1;
        end
      end
    end
  end

  fir_round_sat #(
    .ACC_W    (ACC_W),
    .COEF_FRAC(COEF_FRAC)
  ) u_round_sat (
    .acc_in (acc_q),
    .sat_out(sat_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filter_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= acc_done;
      if (acc_done) begin
        filter_out <= sat_value;
      end
    end
  end

  // Expected index follows the presented index, so one bad tap flags once and
  // the checker then resynchronises to the new position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_idx <= '0;
      seq_err <= 1'b0;
    end else if (tap_valid) begin
      if ((current_count != exp_idx) && (current_count != '0)) begin
        seq_err <= 1'b1;
      end
      exp_idx <= (current_count == LAST_IDX) ? '0 : current_count + 1'b1;
    end
  end

endmodule
